// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: controller bus widths and FSM states.
package sdram_arbiter_pkg;

   localparam int SDRAM_ADDR_W = 25;
   localparam int SDRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      WRWAIT = 2'd3
   } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational grant decision between the two requesters.
// Build option: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin on ties (default: fixed priority, port 0 first).
module sdram_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant1
);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   // On a tie the port that did not win last time goes next.
   assign grant1 = req1 & (~req0 | ~last_grant);
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant1 = req1 & ~req0;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one sdram_controller between a read-only port 0 and a read/write port 1, one access at a time.
// Build option: SDRAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see sdram_arb_pick).
module sdram_arbiter
   import sdram_arbiter_pkg::*;
#(
   parameter int ADDR_W  = SDRAM_ADDR_W,
   parameter int DATA_W  = SDRAM_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   output logic              err,
   output logic [ADDR_W-1:0] sd_wr_addr,
   output logic [DATA_W-1:0] sd_wr_data,
   output logic              sd_wr_enable,
   output logic [ADDR_W-1:0] sd_rd_addr,
   output logic              sd_rd_enable,
   input  logic [DATA_W-1:0] sd_rd_data,
   input  logic              sd_rd_ready,
   input  logic              sd_busy
);

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   arb_state_t        state, state_nxt;
   logic              owner, is_wr, last_grant, grant1;
   logic [7:0]        wd;
   logic              do_grant, rd_done, wd_expire, rd_finish;
   logic [DATA_W-1:0] rd_result;

   sdram_arb_pick u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .grant1     (grant1)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      rd_done   = 1'b0;
      wd_expire = 1'b0;
      case (state)
         IDLE: begin
            if ((req0 | req1) && !sd_busy) begin
               do_grant  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (sd_busy)             state_nxt = is_wr ? WRWAIT : RDWAIT;
            else if (wd == WD_LAST)  wd_expire = 1'b1;
         end
         RDWAIT: begin
            // A rd_ready coinciding with busy falling still completes the read.
            if (sd_rd_ready)         rd_done   = 1'b1;
            else if (wd == WD_LAST)  wd_expire = 1'b1;
         end
         WRWAIT: begin
            if (!sd_busy)            state_nxt = IDLE;
            else if (wd == WD_LAST)  wd_expire = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (rd_done || wd_expire) state_nxt = IDLE;
   end

   // An aborted read still returns a (poisoned) word so the requester never waits forever.
   assign rd_finish = rd_done | (wd_expire & ~is_wr);
   assign rd_result = rd_done ? sd_rd_data : '1;

   always_ff @(posedge clk) begin
      if (reset) begin
         owner        <= 1'b0;
         is_wr        <= 1'b0;
         last_grant   <= 1'b1;
         wd           <= '0;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         rvalid0      <= 1'b0;
         rvalid1      <= 1'b0;
         err          <= 1'b0;
         rdata0       <= '0;
         rdata1       <= '0;
         sd_wr_addr   <= '0;
         sd_wr_data   <= '0;
         sd_wr_enable <= 1'b0;
         sd_rd_addr   <= '0;
         sd_rd_enable <= 1'b0;
      end else begin
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         rvalid0      <= 1'b0;
         rvalid1      <= 1'b0;
         sd_wr_enable <= 1'b0;
         sd_rd_enable <= 1'b0;
         err          <= wd_expire;
         wd           <= (state_nxt != state || state == IDLE) ? 8'd0 : wd + 8'd1;
         if (do_grant) begin
            owner      <= grant1;
            last_grant <= grant1;
            is_wr      <= grant1 & we1;
            ack0       <= ~grant1;
            ack1       <= grant1;
            if (grant1 && we1) begin
               sd_wr_addr   <= addr1;
               sd_wr_data   <= wdata1;
               sd_wr_enable <= 1'b1;
            end else begin
               sd_rd_addr   <= grant1 ? addr1 : addr0;
               sd_rd_enable <= 1'b1;
            end
         end
         if (rd_finish) begin
            if (owner) begin
               rdata1  <= rd_result;
               rvalid1 <= 1'b1;
            end else begin
               rdata0  <= rd_result;
               rvalid0 <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter with a behavioural SDRAM controller and reference model.
module tb_sdram_arbiter;

   localparam int TIMEOUT = 255;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [24:0] addr0 = '0, addr1 = '0;
   logic [7:0]  wdata1 = '0;
   logic        ack0, ack1, rvalid0, rvalid1, err;
   logic [7:0]  rdata0, rdata1;
   logic [24:0] sd_wr_addr, sd_rd_addr;
   logic [7:0]  sd_wr_data;
   logic        sd_wr_enable, sd_rd_enable;
   logic [7:0]  sd_rd_data = '0;
   logic        sd_rd_ready = 1'b0;
   logic        sd_busy;

   // Controller model state
   logic        mdl_busy = 1'b0, ext_busy = 1'b0, no_ready = 1'b0, m_rd = 1'b0;
   logic [24:0] m_addr = '0;
   int          phase = 0;

   // Reference bookkeeping
   int   n_chk = 0, n_fail = 0;
   logic [7:0] last0 = '0, last1 = '0;
   bit   ref_last = 1'b1;
   int   cnt_ack0 = 0, cnt_ack1 = 0, cnt_rv0 = 0, cnt_rv1 = 0, cnt_err = 0, cnt_en = 0;

   assign sd_busy = mdl_busy | ext_busy;

   sdram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0), .rvalid0(rvalid0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .rdata1(rdata1), .rvalid1(rvalid1), .err(err),
      .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
      .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable),
      .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy)
   );

   always #5 clk = ~clk;

   // Controller: busy rises 2 cycles after an enable, stays 6 cycles; read data on the busy-low cycle.
   always @(posedge clk) begin
      sd_rd_ready <= 1'b0;
      if (reset) begin
         phase    <= 0;
         mdl_busy <= 1'b0;
      end else if (phase == 0) begin
         if (sd_rd_enable || sd_wr_enable) begin
            phase  <= 1;
            m_rd   <= sd_rd_enable;
            m_addr <= sd_rd_addr;
         end
      end else begin
         phase <= (phase == 7) ? 0 : phase + 1;
         if (phase == 1) mdl_busy <= 1'b1;
         if (phase == 7) begin
            mdl_busy <= 1'b0;
            if (m_rd && !no_ready) begin
               sd_rd_ready <= 1'b1;
               sd_rd_data  <= m_addr[7:0] ^ 8'h5A;
            end
         end
      end
   end

   // Pulse counters: each cycle's outputs are tallied at the edge that ends it.
   always @(posedge clk) begin
      cnt_ack0 <= cnt_ack0 + int'(ack0);
      cnt_ack1 <= cnt_ack1 + int'(ack1);
      cnt_rv0  <= cnt_rv0 + int'(rvalid0);
      cnt_rv1  <= cnt_rv1 + int'(rvalid1);
      cnt_err  <= cnt_err + int'(err);
      cnt_en   <= cnt_en + int'(sd_wr_enable) + int'(sd_rd_enable);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset    = 1'b0;
      last0    = '0;
      last1    = '0;
      ref_last = 1'b1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pulses"}, {ack0, ack1, rvalid0, rvalid1, err, sd_wr_enable, sd_rd_enable}, 0);
      check({tag, "_addrs"}, {sd_wr_addr, sd_rd_addr}, 0);
      check({tag, "_data"}, {rdata0, rdata1, sd_wr_data}, 0);
   endtask

   // One complete access from a lone requester, checked against the specified timing and data.
   task automatic run_access(input bit port, input bit we, input logic [24:0] addr,
                             input logic [7:0] wd, input bit no_rdy);
      int lat;
      int s_a0, s_a1, s_r0, s_r1, s_e, s_en;
      bit rd;
      logic [7:0] exp_d;
      rd = !(port && we);
      s_a0 = cnt_ack0; s_a1 = cnt_ack1; s_r0 = cnt_rv0; s_r1 = cnt_rv1; s_e = cnt_err; s_en = cnt_en;
      no_ready = no_rdy;
      if (!port) begin
         req0 = 1'b1; addr0 = addr;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
      end
      lat = 0;
      do begin @(negedge clk); lat++; end while (!(port ? ack1 : ack0) && lat < 50);
      check("ack_latency", lat, 1);
      if (rd) begin
         check("rd_enable", {sd_rd_enable, sd_wr_enable}, 2'b10);
         check("rd_addr", sd_rd_addr, addr);
      end else begin
         check("wr_enable", {sd_rd_enable, sd_wr_enable}, 2'b01);
         check("wr_addr_data", {sd_wr_addr, sd_wr_data}, {addr, wd});
      end
      req0 = 1'b0;
      req1 = 1'b0;
      ref_last = port;
      if (rd) begin
         exp_d = no_rdy ? 8'hFF : (addr[7:0] ^ 8'h5A);
         lat = 0;
         do begin @(negedge clk); lat++; end while (!(rvalid0 | rvalid1) && lat < TIMEOUT + 50);
         check("rvalid_latency", lat, no_rdy ? TIMEOUT + 3 : 9);
         check("rvalid_port", {rvalid1, rvalid0}, port ? 2'b10 : 2'b01);
         check("rdata", port ? rdata1 : rdata0, exp_d);
         check("err_with_rvalid", err, no_rdy);
         if (port) last1 = exp_d; else last0 = exp_d;
      end else begin
         repeat (8) @(negedge clk);
      end
      @(negedge clk);
      check("n_ack_owner", port ? cnt_ack1 - s_a1 : cnt_ack0 - s_a0, 1);
      check("n_ack_other", port ? cnt_ack0 - s_a0 : cnt_ack1 - s_a1, 0);
      check("n_enable", cnt_en - s_en, 1);
      check("n_rvalid", (cnt_rv0 - s_r0) + (cnt_rv1 - s_r1), rd);
      check("n_err", cnt_err - s_e, rd && no_rdy);
      check("rdata0_hold", rdata0, last0);
      check("rdata1_hold", rdata1, last1);
      no_ready = 1'b0;
   endtask

   initial begin
      int lat, got, s_r, s_e;
      bit exp_w, p, w, nr;
      logic [24:0] a;
      logic [24:0] tie_addr [2];

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;

      // Directed accesses
      run_access(1'b1, 1'b1, 25'h000010, 8'hC3, 1'b0);
      run_access(1'b0, 1'b0, 25'h000123, 8'h00, 1'b0);
      check("t2_rdata0", rdata0, 8'h79);

      // Both ports requesting continuously for four accesses
      do_reset();
      tie_addr[0] = 25'h0000A5;
      tie_addr[1] = 25'h1F0033;
      req0 = 1'b1; addr0 = tie_addr[0];
      req1 = 1'b1; we1 = 1'b0; addr1 = tie_addr[1];
      for (int k = 0; k < 4; k++) begin
         lat = 0;
         do begin @(negedge clk); lat++; end while (!(ack0 | ack1) && lat < 40);
         exp_w = RR ? !ref_last : 1'b0;
         got = int'(ack1);
         check("tie_winner", got, exp_w);
         check("tie_single_ack", ack0 & ack1, 0);
         ref_last = exp_w;
         if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
         lat = 0;
         do begin @(negedge clk); lat++; end while (!(rvalid0 | rvalid1) && lat < 40);
         check("tie_rvalid_port", {rvalid1, rvalid0}, exp_w ? 2'b10 : 2'b01);
         check("tie_rdata", exp_w ? rdata1 : rdata0, tie_addr[exp_w][7:0] ^ 8'h5A);
         if (exp_w) last1 = tie_addr[1][7:0] ^ 8'h5A; else last0 = tie_addr[0][7:0] ^ 8'h5A;
      end
      @(negedge clk);

      // Watchdog abort of a port 1 read, then normal service
      run_access(1'b1, 1'b0, 25'h000456, 8'h00, 1'b1);
      run_access(1'b1, 1'b0, 25'h000456, 8'h00, 1'b0);

      // Reset one cycle into the read wait
      req0 = 1'b1; addr0 = 25'h0000AB;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!ack0 && lat < 50);
      check("t5_ack", lat, 1);
      req0 = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_outputs_zero("midreset");
      reset = 1'b0;
      last0 = '0; last1 = '0; ref_last = 1'b1;
      s_r = cnt_rv0 + cnt_rv1; s_e = cnt_err;
      repeat (15) @(negedge clk);
      check("t5_silent", (cnt_rv0 + cnt_rv1 - s_r) + (cnt_err - s_e), 0);
      run_access(1'b0, 1'b0, 25'h000321, 8'h00, 1'b0);

      // Request while the controller is held busy externally
      ext_busy = 1'b1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 25'h0ABCDE; wdata1 = 8'h3C;
      got = 0;
      repeat (5) begin
         @(negedge clk);
         got += int'(ack1) + int'(sd_wr_enable) + int'(sd_rd_enable);
      end
      check("t6_no_grant_busy", got, 0);
      ext_busy = 1'b0;
      @(negedge clk);
      check("t6_ack_after_busy", {ack1, sd_wr_enable}, 2'b11);
      check("t6_wr_addr_data", {sd_wr_addr, sd_wr_data}, {25'h0ABCDE, 8'h3C});
      req1 = 1'b0;
      repeat (9) @(negedge clk);

      // Randomized single-requester traffic
      for (int i = 0; i < 24; i++) begin
         p  = 1'($urandom_range(0, 1));
         w  = p ? 1'($urandom_range(0, 1)) : 1'b0;
         a  = 25'($urandom);
         nr = !w && ($urandom_range(0, 9) == 0);
         run_access(p, w, a, 8'($urandom), nr);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
      $finish;
   end

endmodule
